// File: rtl/pipe_stage_regs.sv
// Pipeline inter-stage register banks: F/D, D/X and M/W.
// Each bank loads all of its fields together on an enabled rising edge and
// holds otherwise. An all-zero IR is stored as-is and acts as a bubble.
// Reset is asynchronous and clears every field immediately.
module pipe_stage_regs #(
  parameter int unsigned W = 32
) (
  input  logic         clock,
  input  logic         reset,

  input  logic         fd_en,
  input  logic [W-1:0] fd_ir_d,
  input  logic [W-1:0] fd_pc_d,
  output logic [W-1:0] fd_ir_q,
  output logic [W-1:0] fd_pc_q,

  input  logic         dx_en,
  input  logic [W-1:0] dx_ir_d,
  input  logic [W-1:0] dx_pc_d,
  input  logic [W-1:0] dx_a_d,
  input  logic [W-1:0] dx_b_d,
  output logic [W-1:0] dx_ir_q,
  output logic [W-1:0] dx_pc_q,
  output logic [W-1:0] dx_a_q,
  output logic [W-1:0] dx_b_q,

  input  logic         mw_en,
  input  logic [W-1:0] mw_ir_d,
  input  logic [W-1:0] mw_pc_d,
  input  logic [W-1:0] mw_o_d,
  input  logic [W-1:0] mw_d_d,
  output logic [W-1:0] mw_ir_q,
  output logic [W-1:0] mw_pc_q,
  output logic [W-1:0] mw_o_q,
  output logic [W-1:0] mw_d_q
);

  // F/D bank: instruction and PC captured together
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fd_ir_q <= '0;
      fd_pc_q <= '0;
    end else if (fd_en) begin
      fd_ir_q <= fd_ir_d;
      fd_pc_q <= fd_pc_d;
    end
  end

  // D/X bank: instruction, PC and both register-file operands
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      dx_ir_q <= '0;
      dx_pc_q <= '0;
      dx_a_q  <= '0;
      dx_b_q  <= '0;
    end else if (dx_en) begin
      dx_ir_q <= dx_ir_d;
      dx_pc_q <= dx_pc_d;
      dx_a_q  <= dx_a_d;
      dx_b_q  <= dx_b_d;
    end
  end

  // M/W bank: instruction, PC, ALU result and memory read data
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mw_ir_q <= '0;
      mw_pc_q <= '0;
      mw_o_q  <= '0;
      mw_d_q  <= '0;
    end else if (mw_en) begin
      mw_ir_q <= mw_ir_d;
      mw_pc_q <= mw_pc_d;
      mw_o_q  <= mw_o_d;
      mw_d_q  <= mw_d_d;
    end
  end

endmodule

// File: tb/tb_pipe_stage_regs.sv
// Directed, table-driven bench for pipe_stage_regs.
// Field order in the packed vectors (index 9 down to 0):
// fd_ir, fd_pc, dx_ir, dx_pc, dx_a, dx_b, mw_ir, mw_pc, mw_o, mw_d.
// Enable order: en[2]=fd, en[1]=dx, en[0]=mw.
module tb_pipe_stage_regs;

  localparam int unsigned W = 32;

  typedef logic [9:0][W-1:0] bus_t;

  typedef struct {
    logic [2:0] en;
    bus_t       d;
    bus_t       e;
  } vec_t;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic fd_en, dx_en, mw_en;
  logic [W-1:0] fd_ir_d, fd_pc_d, dx_ir_d, dx_pc_d, dx_a_d, dx_b_d;
  logic [W-1:0] mw_ir_d, mw_pc_d, mw_o_d, mw_d_d;
  logic [W-1:0] fd_ir_q, fd_pc_q, dx_ir_q, dx_pc_q, dx_a_q, dx_b_q;
  logic [W-1:0] mw_ir_q, mw_pc_q, mw_o_q, mw_d_q;
  bus_t q;

  int tests = 0;
  int fails = 0;

  vec_t vecs [9];

  pipe_stage_regs #(.W(W)) dut (
    .clock   (clock),
    .reset   (reset),
    .fd_en   (fd_en),
    .fd_ir_d (fd_ir_d),
    .fd_pc_d (fd_pc_d),
    .fd_ir_q (fd_ir_q),
    .fd_pc_q (fd_pc_q),
    .dx_en   (dx_en),
    .dx_ir_d (dx_ir_d),
    .dx_pc_d (dx_pc_d),
    .dx_a_d  (dx_a_d),
    .dx_b_d  (dx_b_d),
    .dx_ir_q (dx_ir_q),
    .dx_pc_q (dx_pc_q),
    .dx_a_q  (dx_a_q),
    .dx_b_q  (dx_b_q),
    .mw_en   (mw_en),
    .mw_ir_d (mw_ir_d),
    .mw_pc_d (mw_pc_d),
    .mw_o_d  (mw_o_d),
    .mw_d_d  (mw_d_d),
    .mw_ir_q (mw_ir_q),
    .mw_pc_q (mw_pc_q),
    .mw_o_q  (mw_o_q),
    .mw_d_q  (mw_d_q)
  );

  assign q = {fd_ir_q, fd_pc_q, dx_ir_q, dx_pc_q, dx_a_q, dx_b_q,
              mw_ir_q, mw_pc_q, mw_o_q, mw_d_q};

  always #5 clock = ~clock;

  function automatic string fname(int i);
    case (i)
      9: return "fd_ir";
      8: return "fd_pc";
      7: return "dx_ir";
      6: return "dx_pc";
      5: return "dx_a";
      4: return "dx_b";
      3: return "mw_ir";
      2: return "mw_pc";
      1: return "mw_o";
      default: return "mw_d";
    endcase
  endfunction

  task automatic apply(input logic [2:0] en, input bus_t d);
    {fd_en, dx_en, mw_en} = en;
    {fd_ir_d, fd_pc_d, dx_ir_d, dx_pc_d, dx_a_d, dx_b_d,
     mw_ir_d, mw_pc_d, mw_o_d, mw_d_d} = d;
  endtask

  task automatic check_all(input string tag, input bus_t exp);
    for (int j = 0; j < 10; j++) begin
      tests++;
      if (q[j] !== exp[j]) begin
        fails++;
        $display("FAIL %s_%s got=%08h exp=%08h", tag, fname(j), q[j], exp[j]);
      end
    end
  endtask

  bus_t snap;
  bus_t zeros;
  bus_t ones;

  initial begin
    zeros = '0;
    ones  = '1;

    // load all
    vecs[0] = '{3'b111,
      {32'h12345678, 32'h5, 32'h13, 32'h4, 32'hFFFFFFFF, 32'h7, 32'h23, 32'h8, 32'h100, 32'hA5A5A5A5},
      {32'h12345678, 32'h5, 32'h13, 32'h4, 32'hFFFFFFFF, 32'h7, 32'h23, 32'h8, 32'h100, 32'hA5A5A5A5}};
    // stall F/D, advance D/X only
    vecs[1] = '{3'b010,
      {32'hDEADBEEF, 32'h9, 32'h11111111, 32'h22, 32'h33, 32'h44, 32'h55, 32'h66, 32'h77, 32'h88},
      {32'h12345678, 32'h5, 32'h11111111, 32'h22, 32'h33, 32'h44, 32'h23, 32'h8, 32'h100, 32'hA5A5A5A5}};
    // bubble into D/X
    vecs[2] = '{3'b010,
      {32'hDEADBEEF, 32'h9, 32'h0, 32'h30, 32'h80000000, 32'h1, 32'h55, 32'h66, 32'h77, 32'h88},
      {32'h12345678, 32'h5, 32'h0, 32'h30, 32'h80000000, 32'h1, 32'h23, 32'h8, 32'h100, 32'hA5A5A5A5}};
    // M/W only
    vecs[3] = '{3'b001,
      {32'hDEADBEEF, 32'h9, 32'h0, 32'h30, 32'h80000000, 32'h1, 32'h55, 32'h66, 32'h77, 32'h88},
      {32'h12345678, 32'h5, 32'h0, 32'h30, 32'h80000000, 32'h1, 32'h55, 32'h66, 32'h77, 32'h88}};
    // F/D only
    vecs[4] = '{3'b100,
      {32'hDEADBEEF, 32'h9, 32'h0, 32'h30, 32'h80000000, 32'h1, 32'h55, 32'h66, 32'h77, 32'h88},
      {32'hDEADBEEF, 32'h9, 32'h0, 32'h30, 32'h80000000, 32'h1, 32'h55, 32'h66, 32'h77, 32'h88}};
    // nothing enabled: all hold despite new inputs
    vecs[5] = '{3'b000,
      {32'hC0, 32'hC1, 32'hC2, 32'hC3, 32'hC4, 32'hC5, 32'hC6, 32'hC7, 32'hC8, 32'hC9},
      {32'hDEADBEEF, 32'h9, 32'h0, 32'h30, 32'h80000000, 32'h1, 32'h55, 32'h66, 32'h77, 32'h88}};
    // F/D and M/W together, D/X holds
    vecs[6] = '{3'b101,
      {32'hC0, 32'hC1, 32'hC2, 32'hC3, 32'hC4, 32'hC5, 32'hC6, 32'hC7, 32'hC8, 32'hC9},
      {32'hC0, 32'hC1, 32'h0, 32'h30, 32'h80000000, 32'h1, 32'hC6, 32'hC7, 32'hC8, 32'hC9}};
    // all-zero data stored verbatim
    vecs[7] = '{3'b111,
      {32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0},
      {32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0}};
    // D/X and M/W load all-ones, F/D keeps zero
    vecs[8] = '{3'b011,
      {32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF,
       32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF},
      {32'h0, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF,
       32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF}};

    // Reset pulse, checked without any clock edge having cleared it
    apply(3'b000, zeros);
    #2 reset = 1'b1;
    #1 check_all("reset", zeros);
    @(negedge clock) reset = 1'b0;

    // Table vectors: drive at negedge, sample 1 after the rising edge
    for (int i = 0; i < 9; i++) begin
      @(negedge clock) apply(vecs[i].en, vecs[i].d);
      @(posedge clock);
      #1 check_all($sformatf("v%0d", i), vecs[i].e);
    end

    // No combinational path: change every input and enable mid-cycle
    snap = vecs[8].e;
    #2 apply(3'b111, {32'h1, 32'h2, 32'h3, 32'h4, 32'h5, 32'h6, 32'h7, 32'h8, 32'h9, 32'hA});
    #1 check_all("nocomb_mid", snap);
    #1 apply(3'b111, {32'h10, 32'h20, 32'h30, 32'h40, 32'h50, 32'h60, 32'h70, 32'h80, 32'h90, 32'hA0});
    @(posedge clock);
    #1 check_all("nocomb_edge",
      {32'h10, 32'h20, 32'h30, 32'h40, 32'h50, 32'h60, 32'h70, 32'h80, 32'h90, 32'hA0});

    // Async reset mid-cycle with all enables high, held over two edges
    #2 reset = 1'b1;
    #1 check_all("areset_mid", zeros);
    apply(3'b111, ones);
    @(posedge clock);
    #1 check_all("areset_e1", zeros);
    @(posedge clock);
    #1 check_all("areset_e2", zeros);

    // First enabled edge after reset release loads normally
    @(negedge clock) reset = 1'b0;
    apply(3'b110, {32'hAB, 32'hCD, 32'hEF, 32'h12, 32'h34, 32'h56, 32'h78, 32'h9A, 32'hBC, 32'hDE});
    @(posedge clock);
    #1 check_all("post_reset",
      {32'hAB, 32'hCD, 32'hEF, 32'h12, 32'h34, 32'h56, 32'h0, 32'h0, 32'h0, 32'h0});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/pipe_stage_regs.md
PIPE_STAGE_REGS -- requirements
Module: pipe_stage_regs

Interface
REQ-001 The block SHALL have one parameter: W, 32, data width of every stored field.
REQ-002 The block SHALL use a single clock and an asynchronous, active-high reset with these ports:
- clock  in  1  master clock; all capture on its rising edge
- reset  in  1  asynchronous, active-high clear
- fd_en  in  1  F/D bank load enable
- fd_ir_d  in  W  fetched instruction
- fd_pc_d  in  W  fetch PC value
- fd_ir_q  out  W  registered F/D instruction
- fd_pc_q  out  W  registered F/D PC
- dx_en  in  1  D/X bank load enable
- dx_ir_d  in  W  decode instruction (zero = bubble)
- dx_pc_d  in  W  decode PC
- dx_a_d  in  W  register-file operand A
- dx_b_d  in  W  register-file operand B
- dx_ir_q  out  W  registered D/X instruction
- dx_pc_q  out  W  registered D/X PC
- dx_a_q  out  W  registered operand A
- dx_b_q  out  W  registered operand B
- mw_en  in  1  M/W bank load enable
- mw_ir_d  in  W  memory-stage instruction
- mw_pc_d  in  W  memory-stage PC
- mw_o_d  in  W  ALU/address result
- mw_d_d  in  W  data-memory read data
- mw_ir_q  out  W  registered M/W instruction
- mw_pc_q  out  W  registered M/W PC
- mw_o_q  out  W  registered ALU result
- mw_d_q  out  W  registered memory data

Function
REQ-003 The block SHALL contain three independent banks: F/D (IR, PC), D/X (IR, PC, A, B) and M/W (IR, PC, O, D), 10 W-bit registers in total.
REQ-004 On a rising clock edge with reset low and a bank's enable high, every field of that bank SHALL load its _d input atomically.
REQ-005 With a bank's enable low, every field of that bank SHALL hold its value; no partial-bank update is permitted.
REQ-006 Each bank's enable SHALL affect only that bank; the enables may be asserted in any combination on the same edge.
REQ-007 Every _q output SHALL be driven directly by its register, with no combinational path from any _d or enable input; latency from _d to _q is exactly one edge.
REQ-008 Values SHALL pass unmodified (no sign-extension, masking or decoding); an all-zero IR is stored like any other value and denotes a bubble/nop downstream.
REQ-009 A _d input that changes between edges SHALL NOT affect _q until the next enabled edge.

Reset
REQ-010 Asserting reset SHALL immediately, without waiting for a clock edge, drive all ten registers, and therefore every _q output, to 0.
REQ-011 Reset SHALL dominate all enables: while reset is high, no bank loads on any edge.
REQ-012 After reset deasserts, the first rising edge with an enable high SHALL load normally; reset asserted mid-operation SHALL discard all held state.

Verification
REQ-013 Scenario "load all": reset pulse, then all enables=1 with fd_ir_d=0x12345678, fd_pc_d=5, dx_a_d=0xFFFFFFFF, mw_d_d=0xA5A5A5A5 -> each value appears on its _q after one rising edge.
REQ-014 Scenario "stall": fd_en=0, dx_en=1, fd_ir_d changed to 0xDEADBEEF -> fd_ir_q keeps 0x12345678 while dx_* outputs update on the same edge.
REQ-015 Scenario "bubble": dx_ir_d=0, dx_en=1 -> dx_ir_q=0 after the edge; dx_pc_q, dx_a_q and dx_b_q take their inputs.
REQ-016 Scenario "async reset": all outputs nonzero; reset raised between clock edges -> all _q read 0 before the next edge and stay 0 across edges while reset is high, even with all enables=1.
REQ-017 Scenario "no combinational path": change every _d input between edges -> no _q changes until the next rising edge.
